uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter G_DATAWIDTH, default 8, data bits per frame (1..14).
REQ-002 SHALL have parameter G_PRESCALE, default 1302, with one bit period = G_PRESCALE*8 clk cycles (9600 baud @ 100 MHz).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high.
REQ-006 uart_rxdata  output  G_DATAWIDTH  received word, LSB first on line.
REQ-007 uart_rxvalid  output  1  uart_rxdata holds an unconsumed word.
REQ-008 uart_rxready  input  1  consumer accepts the word when high with uart_rxvalid.
REQ-009 busy  output  1  frame reception in progress.
REQ-010 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun_error  output  1  one-cycle pulse: word completed while uart_rxvalid still high.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-013 State machine SHALL have states IDLE, START, DATA, STOP; P = G_PRESCALE, t0 = cycle IDLE first sees rxs=0.
REQ-014 IDLE->START at t0; busy SHALL go high the cycle after t0.
REQ-015 START SHALL sample at t0+4P; rxs=1 -> false start, back to IDLE, no output, no error; rxs=0 -> DATA.
REQ-016 DATA bit k (k=0..G_DATAWIDTH-1) SHALL be sampled at t0+4P+8P*(k+1) and shifted in LSB first.
REQ-017 STOP SHALL sample at t0+4P+8P*(G_DATAWIDTH+1), then return to IDLE the next cycle (mid-stop-bit resync).
REQ-018 Stop sample 1: uart_rxdata loaded and uart_rxvalid set on the next cycle (latency 1 clk after stop sample).
REQ-019 Stop sample 0: frame_error pulses one cycle; word discarded; uart_rxdata/uart_rxvalid unchanged.
REQ-020 uart_rxvalid SHALL stay high and uart_rxdata stable until a cycle with uart_rxready=1; it clears the following cycle.
REQ-021 Good word completing while uart_rxvalid=1 and uart_rxready=0: new word overwrites uart_rxdata, uart_rxvalid stays 1, overrun_error pulses.
REQ-022 Good word completing in the same cycle as acceptance: accept takes effect, new word loaded, uart_rxvalid stays 1, no overrun.
REQ-023 busy SHALL drop the cycle after STOP or false-start exit.
REQ-024 Prescale counter SHALL be 19 bits wide; bit counter SHALL be 4 bits wide; no wrap-around within a frame.
REQ-025 A line held low (break) SHALL yield one frame_error per frame time, then stay in IDLE until rxs returns to 1.

Reset
REQ-026 On clk edge with rst=0: state IDLE; uart_rxdata=0, uart_rxvalid=0, busy=0, frame_error=0, overrun_error=0; counters 0; synchronizer 1.
REQ-027 Reset mid-frame SHALL abort the frame with no output or error pulse; reception restarts on the next falling edge after rst=1.

Configuration
REQ-028 Macro UART_RX_MAJORITY_EN defined: each start/data/stop decision SHALL be the 2-of-3 majority of rxs at cycles N-1, N, N+1 around nominal sample point N, with the decision taking effect at N+1 and all later timing shifted by 1.
REQ-029 UART_RX_MAJORITY_EN undefined: single sample of rxs at N; no extra logic.

Verification (G_PRESCALE=4, bit = 32 clk, G_DATAWIDTH=8)
REQ-030 Frame 0xA5, uart_rxready=1 -> uart_rxvalid one cycle, uart_rxdata=0xA5, no errors.
REQ-031 Two back-to-back frames 0x3C, 0xC3, uart_rxready=0 throughout -> uart_rxdata=0xC3, uart_rxvalid=1, one overrun_error pulse.
REQ-032 Frame 0x55 with stop bit low -> frame_error one pulse, uart_rxvalid stays 0.
REQ-033 Low glitch of 10 clk on idle line -> no busy after START check, no output, no error.
REQ-034 rst low at data bit 4 of frame 0xFF, released, then frame 0x12 -> only 0x12 delivered.
REQ-035 With UART_RX_MAJORITY_EN, frame 0x81 with 1-clk inverted spike at each sample point -> uart_rxdata=0x81.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-word handshake between uart_rx and its consumer.
//   uart_rxdata  : received word (driven by master)
//   uart_rxvalid : word pending (driven by master)
//   uart_rxready : consumer accepts the pending word (driven by slave)
interface uart_rx_if #(parameter int G_DATAWIDTH = 8) ();
  logic [G_DATAWIDTH-1:0] uart_rxdata;
  logic                   uart_rxvalid;
  logic                   uart_rxready;
  modport master (output uart_rxdata, output uart_rxvalid, input uart_rxready);
  modport slave  (input uart_rxdata, input uart_rxvalid, output uart_rxready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready word output.
//   clk           : clock, rising edge
//   rst           : synchronous active-low reset
//   rxd           : asynchronous serial line, idle high
//   rx_if         : uart_rx_if.master (uart_rxdata/uart_rxvalid out, uart_rxready in)
//   busy          : frame reception in progress
//   frame_error   : one-cycle pulse, stop bit sampled low
//   overrun_error : one-cycle pulse, word completed over an unconsumed word
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each
// sample point, decision one cycle later than the nominal point.
module uart_rx #(
  parameter int G_DATAWIDTH = 8,
  parameter int G_PRESCALE  = 1302
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master rx_if,
  output logic      busy,
  output logic      frame_error,
  output logic      overrun_error
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, nxt;
  logic s1, rxs, smp, tick, armed, done_ok, done_bad;
  logic [18:0] cnt;
  logic [3:0] bits;
  logic [G_DATAWIDTH-1:0] sh;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [18:0] OFS = 19'd1;
  logic r1, r2;
  always_ff @(posedge clk)
    if (!rst) {r2, r1} <= 2'b11;
    else {r2, r1} <= {r1, rxs};
  // at cycle N+1: rxs is sample N+1, r1 is N, r2 is N-1
  assign smp = (rxs & r1) | (rxs & r2) | (r1 & r2);
`else
  localparam logic [18:0] OFS = 19'd0;
  assign smp = rxs;
`endif
  localparam logic [18:0] HALF = 19'(4 * G_PRESCALE) + OFS;
  localparam logic [18:0] FULL = 19'(8 * G_PRESCALE);
  // reload so the next decision lands exactly one bit period later
  localparam logic [18:0] RELOAD = 19'd1 + OFS;
  always_ff @(posedge clk)
    if (!rst) {rxs, s1} <= 2'b11;
    else {rxs, s1} <= {s1, rxd};
  assign tick = (state == START) ? (cnt == HALF) : (cnt == FULL + OFS);
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = (!rxs && armed) ? START : IDLE;
      START: nxt = tick ? (smp ? IDLE : DATA) : START;
      DATA:  nxt = (tick && bits == 4'(G_DATAWIDTH - 1)) ? STOP : DATA;
      STOP:  nxt = tick ? IDLE : STOP;
    endcase
  end
  always_comb begin
    busy     = state != IDLE;
    done_ok  = state == STOP && tick && smp;
    done_bad = state == STOP && tick && !smp;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      cnt                <= '0;
      bits               <= '0;
      sh                 <= '0;
      armed              <= 1'b0;
      rx_if.uart_rxdata  <= '0;
      rx_if.uart_rxvalid <= 1'b0;
      frame_error        <= 1'b0;
      overrun_error      <= 1'b0;
    end else begin
      cnt  <= (state == IDLE) ? 19'd1 : tick ? RELOAD : cnt + 19'd1;
      bits <= (state != DATA) ? 4'd0 : bits + 4'(tick);
      if (state == DATA && tick) sh <= (sh >> 1) | (G_DATAWIDTH'(smp) << (G_DATAWIDTH - 1));
      // a break must see the line return high before another frame starts
      armed              <= done_bad ? 1'b0 : (armed | rxs);
      frame_error        <= done_bad;
      overrun_error      <= done_ok && rx_if.uart_rxvalid && !rx_if.uart_rxready;
      rx_if.uart_rxdata  <= done_ok ? sh : rx_if.uart_rxdata;
      rx_if.uart_rxvalid <= done_ok | (rx_if.uart_rxvalid & ~rx_if.uart_rxready);
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (P=4, 32 clk per bit).
module tb_uart_rx;
  localparam int W = 8;
  localparam int P = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic busy, frame_error, overrun_error;
  uart_rx_if #(.G_DATAWIDTH(W)) u_if ();
  uart_rx #(.G_DATAWIDTH(W), .G_PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_if(u_if.master),
    .busy(busy), .frame_error(frame_error), .overrun_error(overrun_error)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_fe = 0, n_oe = 0, n_busy = 0, first_valid = -1;
  logic [W-1:0] last_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u_if.uart_rxvalid) begin
      if (n_valid == 0) first_valid = cyc;
      n_valid++;
      last_data = u_if.uart_rxdata;
    end
    if (frame_error) n_fe++;
    if (overrun_error) n_oe++;
    if (busy) n_busy++;
  end
  task automatic clear();
    @(posedge clk);
    n_valid = 0; n_fe = 0; n_oe = 0; n_busy = 0; first_valid = -1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // frame bits: start, data LSB first, stop; optional 1-clk inverted spike mid-bit
  task automatic send(input logic [W-1:0] d, input logic stop, input bit spike, output int t_fall);
    logic [W+1:0] f;
    f = {stop, d, 1'b0};
    t_fall = 0;
    for (int j = 0; j < W + 2; j++)
      for (int o = 0; o < 8 * P; o++) begin
        @(negedge clk);
        rxd = (spike && o == 4 * P) ? ~f[j] : f[j];
        if (j == 0 && o == 0) t_fall = cyc;
      end
  endtask
  task automatic test_reset();
    rst = 1'b0; rxd = 1'b1; u_if.uart_rxready = 1'b0;
    idle(3);
    checks++; if (u_if.uart_rxdata !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", u_if.uart_rxdata); end
    checks++; if (u_if.uart_rxvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", u_if.uart_rxvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_error); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", overrun_error); end
    rst = 1'b1;
    idle(5);
  endtask
  task automatic test_basic();
    int tf;
    u_if.uart_rxready = 1'b1;
    clear();
    send(8'hA5, 1'b1, 1'b0, tf);
    idle(10);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d want 1", n_valid); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", last_data); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL basic_fe got %0d want 0", n_fe); end
    checks++; if (n_oe !== 0) begin errors++; $display("FAIL basic_oe got %0d want 0", n_oe); end
    checks++; if (n_busy !== 304 + OFS) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", n_busy, 304 + OFS); end
    checks++; if (first_valid - tf !== 307 + OFS) begin errors++; $display("FAIL basic_latency got %0d want %0d", first_valid - tf, 307 + OFS); end
  endtask
  task automatic test_back_to_back();
    int tf;
    u_if.uart_rxready = 1'b0;
    clear();
    send(8'h3C, 1'b1, 1'b0, tf);
    send(8'hC3, 1'b1, 1'b0, tf);
    idle(10);
    checks++; if (u_if.uart_rxdata !== 8'hC3) begin errors++; $display("FAIL b2b_data got %h want c3", u_if.uart_rxdata); end
    checks++; if (u_if.uart_rxvalid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", u_if.uart_rxvalid); end
    checks++; if (n_oe !== 1) begin errors++; $display("FAIL b2b_overrun got %0d want 1", n_oe); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL b2b_fe got %0d want 0", n_fe); end
    u_if.uart_rxready = 1'b1;
    idle(2);
    checks++; if (u_if.uart_rxvalid !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b want 0", u_if.uart_rxvalid); end
  endtask
  task automatic test_frame_error();
    int tf;
    u_if.uart_rxready = 1'b1;
    clear();
    send(8'h55, 1'b0, 1'b0, tf);
    @(negedge clk);
    rxd = 1'b1;
    idle(10);
    checks++; if (n_fe !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", n_fe); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", n_valid); end
    checks++; if (n_oe !== 0) begin errors++; $display("FAIL ferr_oe got %0d want 0", n_oe); end
  endtask
  task automatic test_glitch();
    clear();
    for (int i = 0; i < 10; i++) begin @(negedge clk); rxd = 1'b0; end
    @(negedge clk);
    rxd = 1'b1;
    idle(40);
    checks++; if (n_busy !== 16 + OFS) begin errors++; $display("FAIL glitch_busy_cycles got %0d want %0d", n_busy, 16 + OFS); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", n_valid); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL glitch_fe got %0d want 0", n_fe); end
  endtask
  task automatic test_reset_mid();
    int tf;
    clear();
    for (int i = 0; i < 8 * P; i++) begin @(negedge clk); rxd = 1'b0; end
    for (int i = 0; i < 4 * 8 * P + 4 * P; i++) begin @(negedge clk); rxd = 1'b1; end
    rst = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(200);
    send(8'h12, 1'b1, 1'b0, tf);
    idle(10);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL rstmid_valid_cycles got %0d want 1", n_valid); end
    checks++; if (last_data !== 8'h12) begin errors++; $display("FAIL rstmid_data got %h want 12", last_data); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL rstmid_fe got %0d want 0", n_fe); end
    checks++; if (n_oe !== 0) begin errors++; $display("FAIL rstmid_oe got %0d want 0", n_oe); end
  endtask
  task automatic test_break();
    int tf;
    clear();
    for (int i = 0; i < 700; i++) begin @(negedge clk); rxd = 1'b0; end
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", busy); end
    checks++; if (n_fe !== 1) begin errors++; $display("FAIL break_fe got %0d want 1", n_fe); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL break_valid got %0d want 0", n_valid); end
    rxd = 1'b1;
    idle(20);
    send(8'h5A, 1'b1, 1'b0, tf);
    idle(10);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL break_recover_valid got %0d want 1", n_valid); end
    checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL break_recover_data got %h want 5a", last_data); end
  endtask
`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    int tf;
    u_if.uart_rxready = 1'b1;
    clear();
    send(8'h81, 1'b1, 1'b1, tf);
    idle(10);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL maj_valid_cycles got %0d want 1", n_valid); end
    checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL maj_data got %h want 81", last_data); end
    checks++; if (n_fe !== 0) begin errors++; $display("FAIL maj_fe got %0d want 0", n_fe); end
  endtask
`endif
  initial begin
    u_if.uart_rxready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    test_break();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
